// File: rtl/nios_sysid_pkg.sv
// Shared definitions for the Nios sysid checker: FSM encoding, sysid word
// addresses, default expected values and the ID/timestamp match rule.
package nios_sysid_pkg;

  localparam logic [31:0] SYSID_DEFAULT_ID = 32'h0000_0000;
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'h513C_91C3;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Wide enough for the largest legal READ_LATENCY (4).
  localparam int LAT_CNT_W = 3;

  typedef logic [2:0] sysid_state_t;

  localparam sysid_state_t ST_IDLE    = 3'd0;
  localparam sysid_state_t ST_RD_ID   = 3'd1;
  localparam sysid_state_t ST_WAIT_ID = 3'd2;
  localparam sysid_state_t ST_RD_TS   = 3'd3;
  localparam sysid_state_t ST_WAIT_TS = 3'd4;
  localparam sysid_state_t ST_CMP     = 3'd5;
  localparam sysid_state_t ST_FIN     = 3'd6;

  function automatic logic sysid_match(input logic [31:0] id_word,
                                       input logic [31:0] ts_word,
                                       input logic [31:0] exp_id,
                                       input logic [31:0] exp_ts,
                                       input logic        ts_en);
    return (id_word == exp_id) && (!ts_en || (ts_word == exp_ts));
  endfunction

endpackage

// File: rtl/nios_sysid_lat_cnt.sv
// Read-latency down-counter: loaded on the strobe cycle, flags expiry on the
// cycle whose end is the readdata sample point.
module nios_sysid_lat_cnt
  import nios_sysid_pkg::*;
#(
  parameter int LOAD_VALUE = 1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_load,
  output logic o_expired
);

  logic [LAT_CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LAT_CNT_W'(LOAD_VALUE);
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == LAT_CNT_W'(1));

endmodule

// File: rtl/nios_sysid_checker.sv
// Reads the sysid ID and timestamp words, compares them, and retries on mismatch.
// SYSID_CHECK_TIMESTAMP_EN: when defined, the timestamp also takes part in the match.
module nios_sysid_checker
  import nios_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TS  = SYSID_DEFAULT_TS,
  parameter int          READ_LATENCY = 1,
  parameter int          MAX_RETRIES  = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [3:0]  retry_count
);

`ifdef SYSID_CHECK_TIMESTAMP_EN
  localparam logic LP_TS_EN = 1'b1;
`else
  localparam logic LP_TS_EN = 1'b0;
`endif

  localparam logic [3:0] LP_MAX_RETRIES = 4'(MAX_RETRIES);

  sysid_state_t r_state;
  sysid_state_t w_next;
  logic         r_addr;
  logic         r_pass;
  logic [31:0]  r_id;
  logic [31:0]  r_ts;
  logic [3:0]   r_retry;
  logic         w_load;
  logic         w_expired;
  logic         w_match;
  logic         w_can_retry;

  assign w_load      = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);
  assign w_match     = sysid_match(r_id, r_ts, EXPECTED_ID, EXPECTED_TS, LP_TS_EN);
  assign w_can_retry = (r_retry < LP_MAX_RETRIES);

  nios_sysid_lat_cnt #(
    .LOAD_VALUE(READ_LATENCY)
  ) u_lat_cnt (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_load   (w_load),
    .o_expired(w_expired)
  );

  // NOTE: w_next takes its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_next = ST_RD_ID;
      ST_RD_ID:   w_next = ST_WAIT_ID;
      ST_WAIT_ID: if (w_expired) w_next = ST_RD_TS;
      ST_RD_TS:   w_next = ST_WAIT_TS;
      ST_WAIT_TS: if (w_expired) w_next = ST_CMP;
      ST_CMP: begin
        if (w_match)          w_next = ST_FIN;
        else if (w_can_retry) w_next = ST_RD_ID;
        else                  w_next = ST_FIN;
      end
      ST_FIN:     w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= SYSID_ADDR_ID;
      r_pass  <= 1'b0;
      r_id    <= '0;
      r_ts    <= '0;
      r_retry <= '0;
    end else begin
      r_state <= w_next;

      if (r_state == ST_IDLE && start) begin
        r_pass  <= 1'b0;
        r_retry <= '0;
      end

      // Address is set on entry to a read state and held afterwards.
      if (w_next == ST_RD_ID) r_addr <= SYSID_ADDR_ID;
      if (w_next == ST_RD_TS) r_addr <= SYSID_ADDR_TS;

      if (r_state == ST_WAIT_ID && w_expired) r_id <= sysid_readdata;
      if (r_state == ST_WAIT_TS && w_expired) r_ts <= sysid_readdata;

      if (r_state == ST_CMP) begin
        if (w_match)          r_pass  <= 1'b1;
        else if (w_can_retry) r_retry <= r_retry + 4'd1;
      end
    end
  end

  assign sysid_address = r_addr;
  assign sysid_read    = w_load;
  assign busy          = (r_state != ST_IDLE);
  assign done          = (r_state == ST_FIN);
  assign pass          = r_pass;
  assign id_value      = r_id;
  assign ts_value      = r_ts;
  assign retry_count   = r_retry;

endmodule

// File: tb/tb_nios_sysid_checker.sv
// Randomized self-checking bench: two checker instances (latency 1 and 3)
// against a sysid slave model and a pass-level outcome model.
module tb_nios_sysid_checker;

  localparam int N = 2;
  localparam logic [31:0] EXP_TS = 32'h513C_91C3;
  localparam logic [31:0] EXP_ID1 = 32'h0000_00A5;

`ifdef SYSID_CHECK_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        start_s    [N];
  logic        addr_w     [N];
  logic        read_w     [N];
  logic [31:0] readdata_r [N];
  logic        busy_w     [N];
  logic        done_w     [N];
  logic        pass_w     [N];
  logic [31:0] id_w       [N];
  logic [31:0] ts_w       [N];
  logic [3:0]  rc_w       [N];

  int          lat    [N];
  int          maxr   [N];
  logic [31:0] exp_id [N];

  logic [31:0] id_by_pass [N][16];
  logic [31:0] ts_by_pass [N][16];
  int          since      [N];
  int          cur_pass   [N];
  int          id_reads   [N];
  int          rd_pulses  [N];
  logic        paddr      [N];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  nios_sysid_checker #(
    .EXPECTED_ID (32'h0000_0000),
    .EXPECTED_TS (EXP_TS),
    .READ_LATENCY(1),
    .MAX_RETRIES (3)
  ) dut0 (
    .clock         (clock),
    .reset         (reset),
    .start         (start_s[0]),
    .sysid_address (addr_w[0]),
    .sysid_read    (read_w[0]),
    .sysid_readdata(readdata_r[0]),
    .busy          (busy_w[0]),
    .done          (done_w[0]),
    .pass          (pass_w[0]),
    .id_value      (id_w[0]),
    .ts_value      (ts_w[0]),
    .retry_count   (rc_w[0])
  );

  nios_sysid_checker #(
    .EXPECTED_ID (EXP_ID1),
    .EXPECTED_TS (EXP_TS),
    .READ_LATENCY(3),
    .MAX_RETRIES (2)
  ) dut1 (
    .clock         (clock),
    .reset         (reset),
    .start         (start_s[1]),
    .sysid_address (addr_w[1]),
    .sysid_read    (read_w[1]),
    .sysid_readdata(readdata_r[1]),
    .busy          (busy_w[1]),
    .done          (done_w[1]),
    .pass          (pass_w[1]),
    .id_value      (id_w[1]),
    .ts_value      (ts_w[1]),
    .retry_count   (rc_w[1])
  );

  // Slave model: the correct word is present only on the cycle exactly
  // READ_LATENCY cycles after the strobe; every other cycle carries junk.
  always @(negedge clock) begin : slave
    logic [31:0] word;
    for (int u = 0; u < N; u++) begin
      if (read_w[u]) begin
        since[u] = 0;
        paddr[u] = addr_w[u];
        rd_pulses[u]++;
        if (addr_w[u] == 1'b0) begin
          cur_pass[u] = (id_reads[u] < 15) ? id_reads[u] : 15;
          id_reads[u]++;
        end
      end else if (since[u] < 15) begin
        since[u]++;
      end
      word = paddr[u] ? ts_by_pass[u][cur_pass[u]] : id_by_pass[u][cur_pass[u]];
      if (!read_w[u] && since[u] == lat[u]) readdata_r[u] = word;
      else                                  readdata_r[u] = word ^ ($urandom | 32'h1);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic slave_clear(input int u);
    since[u]     = 15;
    cur_pass[u]  = 0;
    id_reads[u]  = 0;
    rd_pulses[u] = 0;
  endtask

  task automatic fill_good(input int u);
    for (int p = 0; p < 16; p++) begin
      id_by_pass[u][p] = exp_id[u];
      ts_by_pass[u][p] = EXP_TS;
    end
  endtask

  function automatic bit model_match(input int u, input int p);
    return (id_by_pass[u][p] == exp_id[u]) && (!TS_EN || ts_by_pass[u][p] == EXP_TS);
  endfunction

  task automatic check_reset_vals(input int u, input string tag);
    check({tag, " read"},  32'(read_w[u]), 0);
    check({tag, " addr"},  32'(addr_w[u]), 0);
    check({tag, " busy"},  32'(busy_w[u]), 0);
    check({tag, " done"},  32'(done_w[u]), 0);
    check({tag, " pass"},  32'(pass_w[u]), 0);
    check({tag, " id"},    id_w[u], 0);
    check({tag, " ts"},    ts_w[u], 0);
    check({tag, " retry"}, 32'(rc_w[u]), 0);
  endtask

  // One full sequence on instance u, predicted pass-by-pass from the tables.
  task automatic run_seq(input int u, input string tag, input bit spurious);
    int match_p, npass, exp_cycle, cyc;
    bit done_seen;
    match_p = -1;
    for (int p = 0; p <= maxr[u]; p++) begin
      if (model_match(u, p)) begin
        match_p = p;
        break;
      end
    end
    npass     = (match_p < 0) ? maxr[u] + 1 : match_p + 1;
    exp_cycle = (2 * lat[u] + 3) * npass + 1;

    slave_clear(u);
    @(negedge clock);
    start_s[u] = 1'b1;
    cyc = 0;
    done_seen = 1'b0;
    while (!done_seen && cyc < 500) begin
      @(negedge clock);
      cyc++;
      start_s[u] = 1'b0;
      if (done_w[u]) done_seen = 1'b1;
      else if (spurious && busy_w[u] && $urandom_range(0, 2) == 0) start_s[u] = 1'b1;
    end
    check({tag, " done seen"}, 32'(done_seen), 1);
    check({tag, " done cycle"}, cyc, exp_cycle);
    check({tag, " busy at done"}, 32'(busy_w[u]), 1);
    check({tag, " pass"}, 32'(pass_w[u]), 32'(match_p >= 0));
    check({tag, " retry"}, 32'(rc_w[u]), npass - 1);
    check({tag, " id"}, id_w[u], id_by_pass[u][npass-1]);
    check({tag, " ts"}, ts_w[u], ts_by_pass[u][npass-1]);
    check({tag, " read pulses"}, rd_pulses[u], 2 * npass);
    @(negedge clock);
    check({tag, " done pulse"}, 32'(done_w[u]), 0);
    check({tag, " idle"}, 32'(busy_w[u]), 0);
    check({tag, " pass held"}, 32'(pass_w[u]), 32'(match_p >= 0));
    check({tag, " retry held"}, 32'(rc_w[u]), npass - 1);
  endtask

  task automatic randomize_tables(input int u);
    int mp;
    mp = $urandom_range(0, maxr[u] + 1);
    fill_good(u);
    for (int p = 0; p < mp; p++) begin
      if ($urandom_range(0, 1) == 0) begin
        id_by_pass[u][p] = exp_id[u] ^ ($urandom | 32'h1);
        ts_by_pass[u][p] = $urandom;
      end else begin
        ts_by_pass[u][p] = EXP_TS ^ ($urandom | 32'h1);
      end
    end
  endtask

  initial begin
    lat[0] = 1;  maxr[0] = 3;  exp_id[0] = 32'h0;
    lat[1] = 3;  maxr[1] = 2;  exp_id[1] = EXP_ID1;
    for (int u = 0; u < N; u++) begin
      start_s[u]    = 1'b0;
      readdata_r[u] = '0;
      paddr[u]      = 1'b0;
      slave_clear(u);
      fill_good(u);
    end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_vals(0, "por u0");
    check_reset_vals(1, "por u1");
    reset = 1'b0;

    fill_good(0);
    run_seq(0, "good l1", 1'b0);

    fill_good(0);
    for (int p = 0; p < 16; p++) id_by_pass[0][p] = 32'h1;
    run_seq(0, "id always wrong", 1'b0);

    fill_good(0);
    id_by_pass[0][0] = 32'h1;
    run_seq(0, "id wrong once", 1'b0);

    fill_good(0);
    for (int p = 0; p < 16; p++) ts_by_pass[0][p] = 32'hDEAD_BEEF;
    run_seq(0, "ts deadbeef", 1'b1);

    fill_good(1);
    run_seq(1, "good l3", 1'b1);

    // Reset in WAIT_TS, then a coincident reset+start, then a clean run.
    fill_good(0);
    slave_clear(0);
    @(negedge clock);
    start_s[0] = 1'b1;
    @(negedge clock);
    start_s[0] = 1'b0;
    for (int i = 0; i < 20 && !(read_w[0] && addr_w[0]); i++) @(negedge clock);
    check("reach rd_ts", 32'(read_w[0] && addr_w[0]), 1);
    @(negedge clock);
    check("in wait_ts busy", 32'(busy_w[0]), 1);
    reset = 1'b1;
    @(negedge clock);
    check_reset_vals(0, "mid reset");
    start_s[0] = 1'b1;
    @(negedge clock);
    start_s[0] = 1'b0;
    reset = 1'b0;
    check("reset beats start", 32'(busy_w[0]), 0);
    run_seq(0, "after reset", 1'b0);

    for (int k = 0; k < 24; k++) begin
      randomize_tables(k % N);
      run_seq(k % N, $sformatf("rand%0d u%0d", k, k % N), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
